// File: rtl/des_pkg.sv
// Shared types and constants for the iterative DES round sequencer.
package des_pkg;

  localparam int BLK_W   = 64;
  localparam int HALF_W  = 32;
  localparam int KEY_W   = 56;
  localparam int KHALF_W = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Per-round key-half rotation amounts, indexed by round-1.
  localparam logic [1:0] SH [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                     2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  // Decrypt walks the schedule backwards; round 1 uses C0D0 as-is (C16D16 == C0D0).
  localparam logic [1:0] DSH[16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                     2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Bit 27 is DES bit 1 of the half, so "left" moves bits towards the MSB.
  function automatic logic [KHALF_W-1:0] rot28(input logic [KHALF_W-1:0] x,
                                                input logic [1:0] amt,
                                                input logic right);
    case (amt)
      2'd1:    rot28 = right ? {x[0], x[27:1]}   : {x[26:0], x[27]};
      2'd2:    rot28 = right ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
      default: rot28 = x;
    endcase
  endfunction

endpackage

// File: rtl/des_key_rot.sv
// Combinational C/D rotator: each 28-bit half rotated independently by 0..2.
module des_key_rot
  import des_pkg::*;
(
  input  logic [KEY_W-1:0] cd_i,
  input  logic [1:0]       amt_i,
  input  logic             dir_i,   // 0 = left (encrypt), 1 = right (decrypt)
  output logic [KEY_W-1:0] cd_o
);

  assign cd_o = {rot28(cd_i[KEY_W-1:KHALF_W], amt_i, dir_i),
                 rot28(cd_i[KHALF_W-1:0],     amt_i, dir_i)};

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: owns L/R and C/D, drives an external round datapath.
// Optional abort input enabled by defining DES_ABORT_EN.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_decrypt,
  input  logic [HALF_W-1:0] in_l,
  input  logic [HALF_W-1:0] in_r,
  input  logic [KEY_W-1:0]  in_cd,
  output logic [HALF_W-1:0] f_r,
  output logic [KEY_W-1:0]  f_cd,
  input  logic [HALF_W-1:0] f_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLK_W-1:0]  out_block,
`ifdef DES_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy
);

  localparam logic [4:0] LAST = 5'(ROUNDS);

  state_e             state_q, state_d;
  logic [HALF_W-1:0]  l_q, l_d, r_q, r_d;
  logic [KEY_W-1:0]   cd_q, cd_d, cd_rot;
  logic               dec_q, dec_d;
  logic [4:0]         rnd_q, rnd_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [3:0]         tidx;
  logic [1:0]         amt;

  assign tidx = 4'(rnd_q - 5'd1);
  assign amt  = dec_q ? DSH[tidx] : SH[tidx];

  des_key_rot u_rot (
    .cd_i  (cd_q),
    .amt_i (amt),
    .dir_i (dec_q),
    .cd_o  (cd_rot)
  );

  // Outside ROUND the datapath sees the held registers, never X.
  assign f_r       = r_q;
  assign f_cd      = (state_q == ROUND) ? cd_rot : cd_q;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == ROUND);
  assign out_valid = (state_q == DONE);
  assign out_block = blk_q;

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    cd_d    = cd_q;
    dec_d   = dec_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
`ifdef DES_ABORT_EN
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          l_d     = in_l;
          r_d     = in_r;
          cd_d    = in_cd;
          dec_d   = in_decrypt;
          rnd_d   = 5'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        cd_d = cd_rot;
        l_d  = r_q;
        r_d  = l_q ^ f_res;
        if (rnd_q == LAST) begin
          blk_d   = {l_q ^ f_res, r_q};  // R16||L16, final swap folded in
          state_d = DONE;
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      cd_q    <= '0;
      dec_q   <= 1'b0;
      rnd_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cd_q    <= cd_d;
      dec_q   <= dec_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
    end
  end

endmodule
